// File: rtl/tdc_readout_arbiter.sv
// TDC readout arbiter: round-robin grant over NCH channels,
// tags each captured word with channel id and bc_time into a FWFT FIFO.
module tdc_readout_arbiter #(
  parameter int NCH        = 8,
  parameter int DW         = 12,
  parameter int BCW        = 7,
  parameter int FIFO_DEPTH = 8,
  localparam int CW = $clog2(NCH),
  localparam int OW = CW + BCW + DW,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int LW = AW + 1
) (
  input  logic              clk300,
  input  logic              reset,
  input  logic              enable,
  input  logic [NCH-1:0]    ch_rdy,
  input  logic [NCH*DW-1:0] ch_data,
  input  logic [BCW-1:0]    bc_time,
  output logic [NCH-1:0]    ch_ack,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OW-1:0]     out_data,
  output logic [LW-1:0]     fifo_level,
  output logic [7:0]        ovf_count,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACK,
    S_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   grant_q, grant_d;
  logic [CW-1:0]   rr_ptr;
  logic [CW-1:0]   pick_idx;
  logic            start;
  logic            full;
  logic            stall;
  logic            push;
  logic            pop;
  logic [DW-1:0]   sel_data;
  logic [OW-1:0]   push_word;

  logic [OW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  // First requester strictly after rr_ptr, wrapping modulo NCH
  always_comb begin
    logic found;
    int   idx;
    found    = 1'b0;
    idx      = 0;
    pick_idx = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx = (int'(rr_ptr) + i) % NCH;
      if (!found && ch_rdy[CW'(idx)]) begin
        found    = 1'b1;
        pick_idx = CW'(idx);
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (grant_q == CW'(k)) sel_data = ch_data[k*DW +: DW];
    end
  end

  assign full      = (fifo_level == LW'(FIFO_DEPTH));
  assign out_valid = (fifo_level != '0);
  assign push      = (state_q == S_ACK);
  assign pop       = out_valid & out_ready;
  assign push_word = {grant_q, bc_time, sel_data};
  assign busy      = (state_q != S_IDLE);
  assign stall     = (state_q == S_IDLE) & enable
                   & (|ch_rdy) & full;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    start   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable && (|ch_rdy) && !full) begin
          state_d = S_ACK;
          grant_d = pick_idx;
          start   = 1'b1;
        end
      end
      S_ACK:  state_d = S_WAIT;
      S_WAIT: begin
        if (!ch_rdy[grant_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk300 or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      rr_ptr    <= CW'(NCH - 1);
      ch_ack    <= '0;
      ovf_count <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ch_ack  <= start ? (NCH'(1) << pick_idx) : '0;
      if (state_q == S_ACK) rr_ptr <= grant_q;
      if (stall && (ovf_count != 8'hFF)) begin
        ovf_count <= ovf_count + 8'd1;
      end
    end
  end

  // Storage array needs no reset; out_data is masked while empty
  always_ff @(posedge clk300) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk300 or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop) begin
        fifo_level <= fifo_level + LW'(1);
      end else if (pop && !push) begin
        fifo_level <= fifo_level - LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_tdc_readout_arbiter.sv
// Directed bench for tdc_readout_arbiter with an
// expected-word scoreboard checked at every FIFO pop.
module tb_tdc_readout_arbiter;

  localparam int NCH = 8;
  localparam int DW  = 12;
  localparam int BCW = 7;
  localparam int OW  = 3 + BCW + DW;

  logic              clk300;
  logic              reset;
  logic              enable;
  logic [NCH-1:0]    ch_rdy;
  logic [NCH*DW-1:0] ch_data;
  logic [BCW-1:0]    bc_time;
  logic [NCH-1:0]    ch_ack;
  logic              out_valid;
  logic              out_ready;
  logic [OW-1:0]     out_data;
  logic [3:0]        fifo_level;
  logic [7:0]        ovf_count;
  logic              busy;

  tdc_readout_arbiter #(
    .NCH(NCH), .DW(DW), .BCW(BCW), .FIFO_DEPTH(8)
  ) dut (
    .clk300(clk300),
    .reset(reset),
    .enable(enable),
    .ch_rdy(ch_rdy),
    .ch_data(ch_data),
    .bc_time(bc_time),
    .ch_ack(ch_ack),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .fifo_level(fifo_level),
    .ovf_count(ovf_count),
    .busy(busy)
  );

  initial clk300 = 1'b0;
  always #5 clk300 = ~clk300;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit auto_drop = 1'b1;
  logic [OW-1:0] sb [$];
  int gq [$];
  int gc [$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    int k;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("pop_unexpected", 32'(out_valid), 0);
      else chk("pop_word", 32'(out_data), 32'(sb.pop_front()));
    end
    @(posedge clk300);
    #1;
    cyc++;
    if (ch_ack != '0) begin
      chk("ack_onehot", 32'($onehot(ch_ack)), 1);
      k = 0;
      for (int i = 0; i < NCH; i++) if (ch_ack[i]) k = i;
      sb.push_back({3'(k), bc_time, ch_data[k*DW +: DW]});
      gq.push_back(k);
      gc.push_back(cyc);
      if (auto_drop) ch_rdy[k] = 1'b0;
    end
  endtask

  task automatic wait_grants(input int n, input int bound,
                             input string tag);
    int t;
    t = 0;
    while (gq.size() < n && t < bound) begin
      tick();
      t++;
    end
    chk(tag, 32'(gq.size()), 32'(n));
  endtask

  task automatic do_reset();
    ch_rdy = '0;
    reset  = 1'b0;
    repeat (2) @(posedge clk300);
    #1;
    sb.delete();
    gq.delete();
    gc.delete();
    reset = 1'b1;
  endtask

  initial begin
    int rc;
    int pc;
    reset     = 1'b0;
    enable    = 1'b1;
    ch_rdy    = '0;
    ch_data   = '0;
    bc_time   = 7'h15;
    out_ready = 1'b0;
    repeat (2) @(posedge clk300);
    #1;
    chk("rst_ack", 32'(ch_ack), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_ovf", 32'(ovf_count), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b1;

    // single channel
    ch_data[3*DW +: DW] = 12'hABC;
    ch_rdy[3] = 1'b1;
    rc = cyc;
    wait_grants(1, 10, "t1_grant");
    chk("t1_ch", 32'(gq[0]), 3);
    chk("t1_latency", 32'(gc[0] - rc), 1);
    tick();
    tick();
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_level", 32'(fifo_level), 1);
    chk("t1_word", 32'(out_data), 32'({3'd3, 7'h15, 12'hABC}));
    tick();
    chk("t1_once", 32'(gq.size()), 1);
    out_ready = 1'b1;
    tick();
    chk("t1_drain", 32'(fifo_level), 0);

    // all channels, round robin from reset
    do_reset();
    bc_time = 7'h2A;
    for (int k = 0; k < NCH; k++) ch_data[k*DW +: DW] = 12'(12'h100 + k * 17);
    ch_rdy = 8'hFF;
    wait_grants(8, 60, "t2_grants");
    for (int i = 0; i < 8; i++) chk("t2_order", 32'(gq[i]), 32'(i));
    for (int i = 1; i < 8; i++) chk("t2_space", 32'(gc[i] - gc[i-1]), 3);
    tick();
    tick();
    gq.delete();
    gc.delete();
    ch_rdy[0] = 1'b1;
    ch_rdy[5] = 1'b1;
    wait_grants(2, 20, "t2_pair");
    chk("t2_first", 32'(gq[0]), 0);
    chk("t2_second", 32'(gq[1]), 5);
    repeat (4) tick();
    chk("t2_drain", 32'(fifo_level), 0);

    // fill FIFO from channel 2 with consumer stalled
    out_ready = 1'b0;
    bc_time = 7'h33;
    gq.delete();
    gc.delete();
    for (int i = 0; i < 8; i++) begin
      ch_data[2*DW +: DW] = 12'(12'h200 + i);
      ch_rdy[2] = 1'b1;
      wait_grants(i + 1, 10, "t3_grant");
      tick();
      tick();
    end
    chk("t3_level", 32'(fifo_level), 8);
    chk("t3_ovf0", 32'(ovf_count), 0);
    ch_data[2*DW +: DW] = 12'h208;
    ch_rdy[2] = 1'b1;
    repeat (5) tick();
    chk("t3_no9th", 32'(gq.size()), 8);
    chk("t3_ovf5", 32'(ovf_count), 5);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    pc = cyc;
    tick();
    chk("t3_9th", 32'(gq.size()), 9);
    chk("t3_9th_lat", 32'(gc[8] - pc), 1);
    chk("t3_ovf6", 32'(ovf_count), 6);

    // simultaneous push and pop at level 4
    tick();
    tick();
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    chk("t4_level4", 32'(fifo_level), 4);
    ch_data[6*DW +: DW] = 12'h6A5;
    ch_rdy[6] = 1'b1;
    wait_grants(10, 10, "t4_grant");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t4_pushpop", 32'(fifo_level), 4);
    tick();
    out_ready = 1'b1;
    repeat (8) tick();
    chk("t4_drain", 32'(fifo_level), 0);
    chk("t4_sb", 32'(sb.size()), 0);

    // reset in the ACK cycle
    out_ready = 1'b0;
    gq.delete();
    gc.delete();
    ch_rdy[1] = 1'b1;
    wait_grants(1, 10, "t5_g1");
    tick();
    tick();
    ch_rdy[4] = 1'b1;
    wait_grants(2, 10, "t5_g4");
    #2;
    reset = 1'b0;
    #1;
    chk("t5_ack", 32'(ch_ack), 0);
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_level", 32'(fifo_level), 0);
    chk("t5_ovf", 32'(ovf_count), 0);
    chk("t5_busy", 32'(busy), 0);
    sb.delete();
    gq.delete();
    gc.delete();
    ch_rdy = '0;
    #1;
    reset = 1'b1;
    out_ready = 1'b1;
    ch_rdy[0] = 1'b1;
    ch_rdy[5] = 1'b1;
    wait_grants(2, 20, "t5_pair");
    chk("t5_first", 32'(gq[0]), 0);
    chk("t5_second", 32'(gq[1]), 5);
    tick();
    tick();

    // enable gating of grants and stall counting
    out_ready = 1'b0;
    bc_time = 7'h5C;
    gq.delete();
    gc.delete();
    ch_rdy = 8'hFF;
    wait_grants(8, 60, "t6_fill");
    chk("t6_wrap", 32'(gq[0]), 6);
    tick();
    tick();
    chk("t6_full", 32'(fifo_level), 8);
    enable = 1'b0;
    ch_rdy = 8'hFF;
    repeat (10) tick();
    chk("t6_ovf_off", 32'(ovf_count), 0);
    chk("t6_noack", 32'(gq.size()), 8);
    enable = 1'b1;
    repeat (3) tick();
    chk("t6_ovf_on", 32'(ovf_count), 3);
    enable = 1'b0;
    ch_rdy = '0;
    out_ready = 1'b1;
    repeat (10) tick();
    chk("t6_drain", 32'(fifo_level), 0);

    // enable dropped while waiting
    enable = 1'b1;
    auto_drop = 1'b0;
    gq.delete();
    gc.delete();
    ch_data[3*DW +: DW] = 12'h3C3;
    ch_rdy[3] = 1'b1;
    wait_grants(1, 10, "t7_grant");
    tick();
    enable = 1'b0;
    ch_rdy = 8'hFF;
    tick();
    tick();
    chk("t7_busy", 32'(busy), 1);
    ch_rdy[3] = 1'b0;
    repeat (10) tick();
    chk("t7_single", 32'(gq.size()), 1);
    chk("t7_idle", 32'(busy), 0);
    chk("t7_drain", 32'(fifo_level), 0);
    chk("t7_sb", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tdc_readout_arbiter.md
Name: tdc_readout_arbiter

Overview:
- Round-robin readout scheduler for NCH TDC channels sharing one readout path.
- Each channel raises ready with a 12-bit fine-time word. The arbiter grants one channel at a time and pulses its acknowledge.
- The captured word is tagged with channel id and bc_time, then pushed into a small first-word-fall-through FIFO drained by a valid/ready interface.
- Sits between the TDCCHAN array and the event builder, in the clk300 domain.

Parameters:
NCH, 8, number of TDC channels (≥2)
DW, 12, channel data width (tdc_out width)
BCW, 7, bunch-crossing time width
FIFO_DEPTH, 8, output FIFO entries (power of 2, ≥2)

Ports:
clk300  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
enable  in  1  arbitration enable
ch_rdy  in  NCH  per-channel data-ready (level, held until acknowledged)
ch_data  in  NCH*DW  channel words, channel k at [k*DW +: DW]
bc_time  in  BCW  current bunch-crossing count
ch_ack  out  NCH  one-hot, one-cycle acknowledge to granted channel
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head word
out_data  out  $clog2(NCH)+BCW+DW  {ch_id, bc_time, data}, head of FIFO
fifo_level  out  $clog2(FIFO_DEPTH)+1  entries stored
ovf_count  out  8  saturating stall-cycle counter
busy  out  1  state != IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE, ch_ack=0, FIFO empty (out_valid=0, fifo_level=0), out_data=0, ovf_count=0, rr_ptr=NCH-1. Reset takes effect immediately, including mid-transaction.
- FSM states: IDLE, ACK, WAIT.
- IDLE:
  - If enable & |ch_rdy & FIFO not full: pick first set ch_rdy bit searching from rr_ptr+1 upward, wrapping modulo NCH. Register grant g and go to ACK.
  - Otherwise stay in IDLE.
- ACK (exactly one cycle):
  - ch_ack[g]=1.
  - Push {g, bc_time, ch_data[g]} into the FIFO, with bc_time and data sampled this cycle.
  - Set rr_ptr=g and go to WAIT.
- WAIT:
  - Stay while ch_rdy[g]=1; return to IDLE when ch_rdy[g]=0.
  - Other channels are not granted while in WAIT.
- Minimum grant-to-grant spacing is 3 cycles (IDLE→ACK→WAIT→IDLE).
- Latency: a ch_rdy rise seen in IDLE gives ch_ack 1 cycle later. The word appears at out_data the cycle after ACK if the FIFO was empty.
- Round robin: after a grant to g, channel g has lowest priority next decision. Wrap NCH-1→0. From reset, channel 0 has highest priority.
- FIFO:
  - First-word-fall-through; out_valid = level≠0.
  - Pop on out_valid & out_ready. Pop while empty is ignored.
  - Push and pop in the same cycle leave level unchanged.
  - Full is checked only at the IDLE decision. Level cannot rise between the decision and the push, so a push never hits a full FIFO.
  - Pointers wrap modulo FIFO_DEPTH; level saturates at FIFO_DEPTH.
- ovf_count increments in each cycle with state=IDLE & enable & |ch_rdy & FIFO full. It saturates at 255 and clears only on reset.
- enable deasserted in ACK/WAIT: the current transaction completes; no new grant is made.
- ch_rdy[g] already low in the ACK cycle: the push still occurs; WAIT exits on the next cycle.
- ch_ack is registered and glitch-free; at most one bit is ever set.

Test Plan:
- Single channel: ch_rdy[3]=1, data 0xABC, bc_time=0x15, drop rdy after ack → ch_ack[3] pulses once, 1 cycle after rdy. out_data={3,0x15,0xABC}; out_valid=1, fifo_level=1.
- All 8 ch_rdy high, each dropped after its ack, out_ready=1 → grant order 0,1,…,7, each spaced exactly 3 cycles. Then ch_rdy[0] and ch_rdy[5] raised together → 0 granted before 5.
- out_ready=0, 9 requests from channel 2 → 8 words stored, fifo_level=8, no 9th ack. ovf_count counts the stalled cycles. Raising out_ready pops one word; the 9th ack follows 1 cycle later.
- Push/pop in the same cycle with fifo_level=4 → level stays 4. Word order is preserved FIFO.
- Assert reset during ACK → ch_ack=0 immediately, out_valid=0, ovf_count=0. After release, channel 0 has first priority.
- enable=0 with ch_rdy=0xFF → no ack and ovf_count unchanged. Drop enable in WAIT → that transaction completes, then no further grants.
